parking_ctrl_v2: RTL and testbench
==================================

PARKING_CTRL_V2 -- requirements
Module: parking_ctrl_v2

Interface
REQ-001 SHALL have parameter TOTAL, default 700, meaning total parking spaces.
REQ-002 SHALL have parameter W, default 11, meaning width of all count/vacancy outputs; must satisfy 2^W > TOTAL.
REQ-003 SHALL have parameter U_BASE, default 500, meaning university cap during hours 8-12.
REQ-004 SHALL have parameter U_STEP, default 50, meaning university cap decrement per hour during hours 13-15.
REQ-005 SHALL have parameter U_MIN, default 200, meaning university cap outside 8-15; requires U_MIN <= U_BASE-3*U_STEP.
REQ-006 SHALL have parameter CYCLES_PER_HOUR, default 3600, meaning clk cycles per simulated hour.
REQ-007 SHALL have parameter HOUR_START, default 8, meaning hour loaded at reset (0-23).
REQ-008 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port ci, input, 1: public car entry request, one car per cycle high.
REQ-011 SHALL have port uci, input, 1: university car entry request, one car per cycle high.
REQ-012 SHALL have port ce, input, 1: public car exit, one car per cycle high.
REQ-013 SHALL have port uce, input, 1: university car exit, one car per cycle high.
REQ-014 SHALL have port upc, output, W: university cars parked.
REQ-015 SHALL have port pc, output, W: public cars parked.
REQ-016 SHALL have port uvs, output, W: university vacant spaces.
REQ-017 SHALL have port vs, output, W: public vacant spaces.
REQ-018 SHALL have port uivs, output, 1: university invalid-request pulse.
REQ-019 SHALL have port ivs, output, 1: public invalid-request pulse.
REQ-020 SHALL have port hour, output, 5: current hour, 0-23.
REQ-021 SHALL have port full, output, 1: high when upc+pc == TOTAL.

Function
REQ-022 SHALL register all outputs; an event sampled at edge k is reflected in every output after edge k (latency 1 edge).
REQ-023 SHALL count a cycle counter 0..CYCLES_PER_HOUR-1; on the edge where it equals CYCLES_PER_HOUR-1 it wraps to 0 and hour increments, 23 wrapping to 0.
REQ-024 SHALL derive u_cap(hour): 8-12 -> U_BASE; 13,14,15 -> U_BASE-U_STEP*(hour-12); all other hours -> U_MIN.
REQ-025 SHALL judge entries against pre-edge registered uvs/vs; uci accepted iff uvs>0, ci accepted iff vs>0.
REQ-026 SHALL, when uci and ci are both high and exactly one space remains (upc+pc == TOTAL-1), accept uci and reject ci.
REQ-027 SHALL accept uce iff upc>0 and ce iff pc>0; exits and entries in the same cycle both apply (net count change -1, 0 or +1 per class).
REQ-028 SHALL assert uivs for exactly the cycle after any rejected uci or uce, and ivs likewise for ci/ce; counts unchanged by rejected requests.
REQ-029 SHALL compute vacancies from next-state upc, pc, hour: free = TOTAL-upc-pc; uvs = min(sat(u_cap-upc), free); vs = min(sat(TOTAL-max(u_cap,upc)-pc), free); sat() clamps negatives to 0.
REQ-030 SHALL leave parked cars untouched when u_cap shrinks below upc or grows above TOTAL-pc; only vacancies saturate to 0.
REQ-031 SHALL never let upc+pc exceed TOTAL or either count underflow.

Reset
REQ-032 SHALL on rst high at an edge set upc=0, pc=0, uivs=0, ivs=0, full=0, cycle counter=0, hour=HOUR_START, uvs=u_cap(HOUR_START), vs=TOTAL-u_cap(HOUR_START), overriding all requests that cycle.
REQ-033 SHALL discard in-flight requests when rst asserts mid-operation; normal operation resumes on the first edge with rst low.

Verification (bench params TOTAL=20, U_BASE=12, U_STEP=2, U_MIN=4, CYCLES_PER_HOUR=10, HOUR_START=8)
REQ-034 SHALL check reset: rst 1 cycle -> upc=0, pc=0, uvs=12, vs=8, hour=8, full=0, uivs=ivs=0.
REQ-035 SHALL check public fill: ci high 10 cycles after reset -> pc 1..8, vs reaches 0, ivs=1 on the 9th and 10th responses, pc holds 8.
REQ-036 SHALL check simultaneous events: pc=8, uci=1 and ce=1 one cycle -> upc=1, pc=7, uvs=11, vs=1, no flags.
REQ-037 SHALL check schedule: idle from reset, 50 cycles -> hour=13, uvs=10, vs=10; 80 cycles -> hour=16, uvs=4, vs=16; 240 cycles -> hour wraps to 8.
REQ-038 SHALL check shrink/full: upc=12 at hour 8, advance to hour 16 -> upc stays 12, uvs=0, vs=8, uci rejected with uivs=1; add 8 ci -> full=1, vs=0.
REQ-039 SHALL check underflow and mid-run reset: uce with upc=0 -> uivs=1, upc=0; rst during ci burst -> all REQ-032 values next cycle.

Source files
------------

// File: rtl/parking_ctrl_v2.sv
// parking_ctrl_v2 -- car park occupancy controller with an hourly university cap.
//
// Purpose:
//   Tracks university and public cars in a shared car park of TOTAL spaces.
//   The number of spaces reserved for university cars (u_cap) follows the
//   simulated hour of day. A free-running cycle counter advances the hour.
//   Entries are judged against the registered vacancies. Exits are judged
//   against the registered counts. Rejected requests raise a one-cycle pulse.
//   Every output is registered, so an event sampled at edge k is visible
//   after edge k.
//
// Ports:
//   clk   in   1  clock, rising edge
//   rst   in   1  synchronous active-high reset
//   ci    in   1  public entry request (one car per high cycle)
//   uci   in   1  university entry request
//   ce    in   1  public exit
//   uce   in   1  university exit
//   upc   out  W  university cars parked
//   pc    out  W  public cars parked
//   uvs   out  W  university vacant spaces
//   vs    out  W  public vacant spaces
//   uivs  out  1  university invalid-request pulse
//   ivs   out  1  public invalid-request pulse
//   hour  out  5  current hour 0..23
//   full  out  1  upc + pc == TOTAL
module parking_ctrl_v2 #(
    parameter int TOTAL           = 700,
    parameter int W               = 11,
    parameter int U_BASE          = 500,
    parameter int U_STEP          = 50,
    parameter int U_MIN           = 200,
    parameter int CYCLES_PER_HOUR = 3600,
    parameter int HOUR_START      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ci,
    input  logic         uci,
    input  logic         ce,
    input  logic         uce,
    output logic [W-1:0] upc,
    output logic [W-1:0] pc,
    output logic [W-1:0] uvs,
    output logic [W-1:0] vs,
    output logic         uivs,
    output logic         ivs,
    output logic [4:0]   hour,
    output logic         full
);

    localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

    // University cap as a function of hour: flat in the morning, tapering
    // over 13..15, minimum the rest of the day.
    function automatic int cap_of(input int h);
        if (h >= 8 && h <= 12)       return U_BASE;
        else if (h >= 13 && h <= 15) return U_BASE - U_STEP * (h - 12);
        else                         return U_MIN;
    endfunction

    localparam int RST_CAP = cap_of(HOUR_START);

    logic [W-1:0]  upc_q, upc_d, pc_q, pc_d, uvs_q, uvs_d, vs_q, vs_d;
    logic          uivs_q, uivs_d, ivs_q, ivs_d, full_q, full_d;
    logic [4:0]    hour_q, hour_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic u_in, u_out, c_in, c_out, last_space;
    int   cap_c, free_c, ua_c, pa_c, umax_c;

    // Time of day
    always_comb begin
        cyc_d  = cyc_q + CW'(1);
        hour_d = hour_q;
        if (cyc_q == CW'(CYCLES_PER_HOUR - 1)) begin
            cyc_d  = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    // Request arbitration and next-state counts
    always_comb begin
        u_in       = uci && (uvs_q != '0);
        u_out      = uce && (upc_q != '0);
        c_out      = ce  && (pc_q  != '0);
        last_space = (int'(upc_q) + int'(pc_q) == TOTAL - 1);
        // On the last free space a university entry wins over a public one.
        c_in       = ci && (vs_q != '0) && !(u_in && last_space);

        uivs_d = (uci && !u_in) || (uce && !u_out);
        ivs_d  = (ci  && !c_in) || (ce  && !c_out);

        upc_d = upc_q + W'(u_in) - W'(u_out);
        pc_d  = pc_q  + W'(c_in) - W'(c_out);
    end

    // Vacancies from next-state counts and hour. Parked cars are never
    // evicted when the cap moves; only the vacancies clamp at zero.
    always_comb begin
        cap_c  = cap_of(int'(hour_d));
        free_c = TOTAL - int'(upc_d) - int'(pc_d);
        umax_c = (cap_c > int'(upc_d)) ? cap_c : int'(upc_d);

        ua_c = cap_c - int'(upc_d);
        if (ua_c < 0)      ua_c = 0;
        if (ua_c > free_c) ua_c = free_c;

        pa_c = TOTAL - umax_c - int'(pc_d);
        if (pa_c < 0)      pa_c = 0;
        if (pa_c > free_c) pa_c = free_c;

        uvs_d  = W'(ua_c);
        vs_d   = W'(pa_c);
        full_d = (free_c == 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q  <= '0;
            pc_q   <= '0;
            uvs_q  <= W'(RST_CAP);
            vs_q   <= W'(TOTAL - RST_CAP);
            uivs_q <= 1'b0;
            ivs_q  <= 1'b0;
            full_q <= 1'b0;
            hour_q <= 5'(HOUR_START);
            cyc_q  <= '0;
        end else begin
            upc_q  <= upc_d;
            pc_q   <= pc_d;
            uvs_q  <= uvs_d;
            vs_q   <= vs_d;
            uivs_q <= uivs_d;
            ivs_q  <= ivs_d;
            full_q <= full_d;
            hour_q <= hour_d;
            cyc_q  <= cyc_d;
        end
    end

    assign upc  = upc_q;
    assign pc   = pc_q;
    assign uvs  = uvs_q;
    assign vs   = vs_q;
    assign uivs = uivs_q;
    assign ivs  = ivs_q;
    assign full = full_q;
    assign hour = hour_q;

endmodule

// File: tb/tb_parking_ctrl_v2.sv
// Testbench for parking_ctrl_v2: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the car park.
module tb_parking_ctrl_v2;

    localparam int TOTAL = 20;
    localparam int W     = 5;
    localparam int UB    = 12;
    localparam int US    = 2;
    localparam int UM    = 4;
    localparam int CPH   = 10;
    localparam int HS    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0, ci = 1'b0, uci = 1'b0, ce = 1'b0, uce = 1'b0;
    logic [W-1:0] upc, pc, uvs, vs;
    logic uivs, ivs, full;
    logic [4:0] hour;

    int n_chk = 0;
    int n_err = 0;

    parking_ctrl_v2 #(
        .TOTAL(TOTAL), .W(W), .U_BASE(UB), .U_STEP(US), .U_MIN(UM),
        .CYCLES_PER_HOUR(CPH), .HOUR_START(HS)
    ) dut (
        .clk(clk), .rst(rst), .ci(ci), .uci(uci), .ce(ce), .uce(uce),
        .upc(upc), .pc(pc), .uvs(uvs), .vs(vs),
        .uivs(uivs), .ivs(ivs), .hour(hour), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_upc, m_pc, m_uvs, m_vs, m_hour, m_cyc;
    int m_uivs, m_ivs, m_full;

    function automatic int mcap(input int h);
        case (h)
            8, 9, 10, 11, 12: return UB;
            13:               return UB - US;
            14:               return UB - 2 * US;
            15:               return UB - 3 * US;
            default:          return UM;
        endcase
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_vac();
        int free = TOTAL - m_upc - m_pc;
        int cap  = mcap(m_hour);
        m_uvs  = imin(imax(cap - m_upc, 0), free);
        m_vs   = imin(imax(TOTAL - imax(cap, m_upc) - m_pc, 0), free);
        m_full = (free == 0) ? 1 : 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit u, input bit e, input bit ue);
        bit ua, ca, uo, co;
        if (r) begin
            m_upc = 0; m_pc = 0; m_uivs = 0; m_ivs = 0;
            m_hour = HS; m_cyc = 0;
        end else begin
            ua = u && (m_uvs > 0);
            ca = c && (m_vs > 0) && !(ua && (m_upc + m_pc == TOTAL - 1));
            uo = ue && (m_upc > 0);
            co = e && (m_pc > 0);
            m_uivs = ((u && !ua) || (ue && !uo)) ? 1 : 0;
            m_ivs  = ((c && !ca) || (e && !co)) ? 1 : 0;
            m_upc  = m_upc + int'(ua) - int'(uo);
            m_pc   = m_pc + int'(ca) - int'(co);
            m_cyc++;
            if (m_cyc == CPH) begin
                m_cyc  = 0;
                m_hour = (m_hour + 1) % 24;
            end
        end
        model_vac();
    endtask

    // One clock: drive, advance model at the edge, then sample 1 time unit later.
    task automatic step(input bit r, input bit c, input bit u, input bit e, input bit ue);
        rst = r; ci = c; uci = u; ce = e; uce = ue;
        @(posedge clk);
        model_step(r, c, u, e, ue);
        #1;
        chk("upc",  upc,  m_upc);
        chk("pc",   pc,   m_pc);
        chk("uvs",  uvs,  m_uvs);
        chk("vs",   vs,   m_vs);
        chk("uivs", uivs, m_uivs);
        chk("ivs",  ivs,  m_ivs);
        chk("hour", hour, m_hour);
        chk("full", full, m_full);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0);
        chk("rst_upc", upc, 0);   chk("rst_pc", pc, 0);
        chk("rst_uvs", uvs, 12);  chk("rst_vs", vs, 8);
        chk("rst_hour", hour, 8); chk("rst_full", full, 0);
        chk("rst_uivs", uivs, 0); chk("rst_ivs", ivs, 0);

        // Public fill: 8 accepted, then rejections flagged
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0, 0, 0);
            chk("fill_pc", pc, (i < 8) ? i : 8);
            chk("fill_ivs", ivs, (i >= 9) ? 1 : 0);
        end
        chk("fill_vs", vs, 0);

        // Simultaneous university entry and public exit
        step(0, 0, 1, 1, 0);
        chk("sim_upc", upc, 1); chk("sim_pc", pc, 7);
        chk("sim_uvs", uvs, 11); chk("sim_vs", vs, 1);
        chk("sim_uivs", uivs, 0); chk("sim_ivs", ivs, 0);

        // Schedule
        step(1, 0, 0, 0, 0);
        idle(50);
        chk("sch13_hour", hour, 13); chk("sch13_uvs", uvs, 10); chk("sch13_vs", vs, 10);
        idle(30);
        chk("sch16_hour", hour, 16); chk("sch16_uvs", uvs, 4); chk("sch16_vs", vs, 16);
        idle(160);
        chk("wrap_hour", hour, 8);

        // Cap shrinks below parked university cars, then fill to full
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        chk("shr_upc12", upc, 12);
        idle(68);
        chk("shr_hour", hour, 16); chk("shr_upc", upc, 12);
        chk("shr_uvs", uvs, 0);    chk("shr_vs", vs, 8);
        step(0, 0, 1, 0, 0);
        chk("shr_uivs", uivs, 1);  chk("shr_upc_hold", upc, 12);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        chk("full_flag", full, 1); chk("full_vs", vs, 0); chk("full_pc", pc, 8);

        // Underflow and mid-burst reset
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("uf_uivs", uivs, 1); chk("uf_upc", upc, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("burst_pc", pc, 3);
        step(1, 1, 0, 0, 0);
        chk("mrst_pc", pc, 0);   chk("mrst_upc", upc, 0);
        chk("mrst_uvs", uvs, 12); chk("mrst_vs", vs, 8);
        chk("mrst_hour", hour, 8); chk("mrst_full", full, 0);
        chk("mrst_ivs", ivs, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
